// File: rtl/sw_cond_pkg.sv
// Shared constants and types for the slide-switch conditioner.
// The optional rise/fall pulse outputs are enabled by SW_COND_EDGE_EN.
package sw_cond_pkg;

  localparam int SW_WIDTH_DEF = 4;
  localparam int SW_DEB_SIM   = 16;
  localparam int SW_DEB_HW    = 1_000_000;  // 10 ms at 100 MHz

  typedef enum logic {
    STABLE,
    PENDING
  } sw_deb_state_e;

endpackage

// File: rtl/sw_conditioner_if.sv
// Switch bundle between the raw pins and the conditioned consumers.
// sw_rise/sw_fall exist only when SW_COND_EDGE_EN is defined.
interface sw_conditioner_if
  import sw_cond_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH_DEF
);

  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_level;
  logic             sw_changed;
`ifdef SW_COND_EDGE_EN
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
`endif

  modport master (
    input  sw,
    output sw_level,
    output sw_changed
`ifdef SW_COND_EDGE_EN
    ,
    output sw_rise,
    output sw_fall
`endif
  );

  modport slave (
    output sw,
    input  sw_level,
    input  sw_changed
`ifdef SW_COND_EDGE_EN
    ,
    input  sw_rise,
    input  sw_fall
`endif
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchroniser, stability counter, level register
// and registered change pulses (rise/fall only with SW_COND_EDGE_EN).
module sw_debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEB_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic level,
  output logic changed
`ifdef SW_COND_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("sw_debounce_bit: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // sw_raw -> s1 is the only asynchronous crossing in the block.
  (* ASYNC_REG = "TRUE" *) logic s1;
  (* ASYNC_REG = "TRUE" *) logic s2;

  logic [CNT_W-1:0] cnt;
  sw_deb_state_e    state;
  logic             accept;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    state  = (s2 == level) ? STABLE : PENDING;
    accept = (state == PENDING) && (cnt == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      changed <= 1'b0;
`ifdef SW_COND_EDGE_EN
      rise    <= 1'b0;
      fall    <= 1'b0;
`endif
    end else begin
      s1      <= sw_raw;
      s2      <= s1;
      changed <= accept;
`ifdef SW_COND_EDGE_EN
      rise    <= accept & s2;
      fall    <= accept & ~s2;
`endif
      // A glitch back to the current level clears the count; accept stops it wrapping.
      if (state == STABLE || accept) cnt <= '0;
      else                           cnt <= cnt + 1'b1;
      if (accept) level <= s2;
    end
  end

endmodule

// File: rtl/sw_conditioner.sv
// Debounced switch conditioner: WIDTH independent channels plus a combined
// change pulse. Rise/fall pulse outputs are present only with SW_COND_EDGE_EN.
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = SW_DEB_SIM
) (
  input  logic              clk,
  input  logic              rst,
  sw_conditioner_if.master  sw_bus
);

  logic [WIDTH-1:0] changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .sw_raw  (sw_bus.sw[i]),
      .level   (sw_bus.sw_level[i]),
      .changed (changed[i])
`ifdef SW_COND_EDGE_EN
      ,
      .rise    (sw_bus.sw_rise[i]),
      .fall    (sw_bus.sw_fall[i])
`endif
    );
  end

  // The per-bit pulses are already registered, so the OR lines up with them.
  assign sw_bus.sw_changed = |changed;

endmodule

// File: tb/tb_sw_conditioner.sv
// Scoreboard bench for sw_conditioner (WIDTH=4, DEBOUNCE_CYCLES=4); works in
// both the SW_COND_EDGE_EN build and the default build.
module tb_sw_conditioner;
  import sw_cond_pkg::*;

  localparam int W   = 4;
  localparam int DEB = 4;

  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic clk;
  logic rst;

  sw_conditioner_if #(.WIDTH(W)) bus ();

  sw_conditioner #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a level flips once DEB consecutive synchronised samples
  // (raw input delayed two edges) disagree with it; reset clears everything.
  exp_t         exp_q[$];
  logic [W-1:0] m_d1, m_d2, m_level, m_samp, m_rise, m_fall;
  int           run[W];
  bit           started = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_d1    = '0;
      m_d2    = '0;
      m_level = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
      exp_q.delete();
    end else begin
      m_samp = m_d2;
      m_d2   = m_d1;
      m_d1   = bus.sw;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_samp[i] == m_level[i]) begin
          run[i] = 0;
        end else begin
          run[i]++;
          if (run[i] == DEB) begin
            run[i]     = 0;
            m_level[i] = m_samp[i];
            if (m_samp[i]) m_rise[i] = 1'b1;
            else           m_fall[i] = 1'b1;
          end
        end
      end
      if ((m_rise | m_fall) != '0) exp_q.push_back('{m_level, m_rise, m_fall});
    end
  end

  // Monitor: on every cycle compare the DUT against the model, popping the
  // expected pulse whenever either side presents one.
  exp_t e;
  bit   exp_chg;

  always @(negedge clk) begin
    if (started) begin
      exp_chg = (exp_q.size() > 0);
      e       = '0;
      check("sw_level", 32'(bus.sw_level), 32'(m_level));
      check("sw_changed", 32'(bus.sw_changed), 32'(exp_chg));
      if (exp_chg) e = exp_q.pop_front();
`ifdef SW_COND_EDGE_EN
      check("sw_rise", 32'(bus.sw_rise), 32'(e.rise));
      check("sw_fall", 32'(bus.sw_fall), 32'(e.fall));
`endif
    end
  end

  task automatic hold(input logic [W-1:0] v, input int n);
    bus.sw = v;
    repeat (n) @(negedge clk);
  endtask

  logic [W-1:0] rv;
  int           rn;

  initial begin
    rst    = 1'b1;
    bus.sw = 4'b1111;

    // Switches held high through reset, then re-debounced after release.
    repeat (10) @(negedge clk);
    rst = 1'b0;
    hold(4'b1111, 12);

    // Single-bit rise then fall.
    hold(4'b0000, 12);
    hold(4'b0001, 12);
    hold(4'b0000, 12);

    // Short glitches on bit 2 must be rejected.
    repeat (5) begin
      hold(4'b0100, 3);
      hold(4'b0000, 3);
    end
    hold(4'b0000, 8);

    // Opposite transitions on two bits at the same edge.
    hold(4'b0001, 12);
    hold(4'b1000, 12);

    // Reset at edge 3 of a pending change.
    hold(4'b0000, 12);
    bus.sw = 4'b0010;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(4'b0010, 12);

    // Random switch activity with occasional resets.
    repeat (150) begin
      rv = W'($urandom_range(0, 15));
      rn = $urandom_range(1, 9);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      hold(rv, rn);
    end
    hold(bus.sw, 12);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
